// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece controller: movement codes,
// board bounds, FSM states and the spawn-shape table.
package tetris_pkg;

    localparam int COLS = 10;
    localparam int ROWS = 20;

    localparam logic [3:0] MV_IDLE  = 4'b0000;
    localparam logic [3:0] MV_DOWN  = 4'b0001;
    localparam logic [3:0] MV_LEFT  = 4'b0011;
    localparam logic [3:0] MV_RIGHT = 4'b0100;
    localparam logic [3:0] MV_ROT   = 4'b1000;

    localparam logic [2:0] TYPE_O = 3'd2;

    typedef enum logic [1:0] {
        ST_SPAWN,
        ST_ACTIVE,
        ST_APPLY
    } state_t;

    // Element 0 is cell1; element 1 (cell2) is the rotation pivot.
    typedef logic [3:0][3:0] col_arr_t;
    typedef logic [3:0][4:0] row_arr_t;

    typedef struct packed {
        col_arr_t x;
        row_arr_t y;
    } cells_t;

    function automatic cells_t spawn_cells(input logic [2:0] kind);
        cells_t c;
        c.x = '0;
        c.y = '0;
        case (kind)
            3'd1: begin
                c.x = {4'd6, 4'd5, 4'd4, 4'd3};
                c.y = {5'd0, 5'd0, 5'd0, 5'd0};
            end
            3'd2: begin
                c.x = {4'd5, 4'd4, 4'd5, 4'd4};
                c.y = {5'd1, 5'd1, 5'd0, 5'd0};
            end
            3'd3: begin
                c.x = {4'd4, 4'd5, 4'd4, 4'd3};
                c.y = {5'd1, 5'd0, 5'd0, 5'd0};
            end
            3'd4: begin
                c.x = {4'd3, 4'd4, 4'd4, 4'd5};
                c.y = {5'd1, 5'd1, 5'd0, 5'd0};
            end
            3'd5: begin
                c.x = {4'd3, 4'd5, 4'd4, 4'd3};
                c.y = {5'd1, 5'd0, 5'd0, 5'd0};
            end
            3'd6: begin
                c.x = {4'd5, 4'd4, 4'd4, 4'd3};
                c.y = {5'd1, 5'd1, 5'd0, 5'd0};
            end
            3'd7: begin
                c.x = {4'd5, 4'd5, 4'd4, 4'd3};
                c.y = {5'd1, 5'd0, 5'd0, 5'd0};
            end
            default: begin
                c.x = '0;
                c.y = '0;
            end
        endcase
        return c;
    endfunction

    // x^3 + x^2 + 1, shifting toward the MSB; the all-zero state is unreachable.
    function automatic logic [2:0] lfsr_step(input logic [2:0] s);
        return {s[1:0], s[2] ^ s[1]};
    endfunction

endpackage

// File: rtl/piece_candidate.sv
// Combinational candidate position for the active piece: shift, drop or
// clockwise rotation about cell2, with the whole move cancelled if any cell leaves the board.
module piece_candidate
    import tetris_pkg::*;
(
    input  logic [3:0][3:0] cur_x,
    input  logic [3:0][4:0] cur_y,
    input  logic [2:0]      block_type,
    input  logic [3:0]      movement,
    output logic [3:0][3:0] next_x,
    output logic [3:0][4:0] next_y
);

    localparam logic signed [5:0] X_MAX   = 6'(COLS - 1);
    localparam logic signed [5:0] Y_MAX   = 6'(ROWS - 1);
    localparam logic signed [5:0] Y_FLOOR = 6'(ROWS);

    logic signed [5:0] px;
    logic signed [5:0] py;
    logic signed [5:0] sx [4];
    logic signed [5:0] sy [4];
    logic signed [5:0] cx [4];
    logic signed [5:0] cy [4];
    logic              oob;

    assign px = signed'({2'b00, cur_x[1]});
    assign py = signed'({1'b0, cur_y[1]});

    always_comb begin
        oob = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sx[i] = signed'({2'b00, cur_x[i]});
            sy[i] = signed'({1'b0, cur_y[i]});
            cx[i] = sx[i];
            cy[i] = sy[i];
            case (movement)
                MV_LEFT:  cx[i] = sx[i] - 6'sd1;
                MV_RIGHT: cx[i] = sx[i] + 6'sd1;
                MV_DOWN:  cy[i] = sy[i] + 6'sd1;
                MV_ROT: begin
                    if (block_type != TYPE_O) begin
                        cx[i] = px - (sy[i] - py);
                        cy[i] = py + (sx[i] - px);
                    end
                end
                default: ;
            endcase
            if (cx[i] < 6'sd0 || cx[i] > X_MAX || cy[i] < 6'sd0)
                oob = 1'b1;
            // A drop may land on row 20: the board's floor row rejects it there.
            if (movement == MV_DOWN) begin
                if (cy[i] > Y_FLOOR)
                    oob = 1'b1;
            end else if (cy[i] > Y_MAX) begin
                oob = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            next_x[i] = oob ? cur_x[i] : cx[i][3:0];
            next_y[i] = oob ? cur_y[i] : cy[i][4:0];
        end
    end

endmodule

// File: rtl/piece_controller.sv
// Active-tetromino controller: spawns pieces from an LFSR, arbitrates
// player and gravity requests, and commits board-filtered coordinates.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_SPAWN  | load a new piece of type = LFSR, clear pending and timer
// ST_ACTIVE | pick highest-priority pending request, drive movement
// ST_APPLY  | candidate stable for one cycle; commit changed_* at edge
module piece_controller
    import tetris_pkg::*;
#(
    parameter int         DROP_TICKS = 30,
    parameter logic [2:0] LFSR_SEED  = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    input  logic       btn_down,
    input  logic       block_logic_reset,
    input  logic       game_over_logic,
    input  logic [3:0] changed_x1,
    input  logic [3:0] changed_x2,
    input  logic [3:0] changed_x3,
    input  logic [3:0] changed_x4,
    input  logic [4:0] changed_y1,
    input  logic [4:0] changed_y2,
    input  logic [4:0] changed_y3,
    input  logic [4:0] changed_y4,
    output logic [3:0] x1,
    output logic [3:0] x2,
    output logic [3:0] x3,
    output logic [3:0] x4,
    output logic [4:0] y1,
    output logic [4:0] y2,
    output logic [4:0] y3,
    output logic [4:0] y4,
    output logic [3:0] x1_next_out,
    output logic [3:0] x2_next_out,
    output logic [3:0] x3_next_out,
    output logic [3:0] x4_next_out,
    output logic [4:0] y1_next_out,
    output logic [4:0] y2_next_out,
    output logic [4:0] y3_next_out,
    output logic [4:0] y4_next_out,
    output logic [3:0] movement,
    output logic [2:0] block_type
);

    localparam int            CW       = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DROP_TICKS - 1);

    state_t        state;
    logic [2:0]    lfsr;
    logic [4:0]    pend;
    logic [CW-1:0] drop_cnt;
    col_arr_t      cur_x;
    row_arr_t      cur_y;
    col_arr_t      nxt_x;
    row_arr_t      nxt_y;
    col_arr_t      chg_x;
    row_arr_t      chg_y;
    cells_t        spawn;
    logic          grav_tick;
    logic [4:0]    pend_set;
    logic [4:0]    pend_clr;
    logic [3:0]    sel_mv;

    assign chg_x = {changed_x4, changed_x3, changed_x2, changed_x1};
    assign chg_y = {changed_y4, changed_y3, changed_y2, changed_y1};

    assign {x4, x3, x2, x1} = cur_x;
    assign {y4, y3, y2, y1} = cur_y;
    assign {x4_next_out, x3_next_out, x2_next_out, x1_next_out} = nxt_x;
    assign {y4_next_out, y3_next_out, y2_next_out, y1_next_out} = nxt_y;

    assign spawn     = spawn_cells(lfsr);
    assign grav_tick = ce && (drop_cnt == CNT_LAST);

    // Bit order is also the service priority: rotate, left, right, down, gravity.
    assign pend_set = {btn_rotate, btn_left, btn_right, btn_down, grav_tick};

    always_comb begin
        sel_mv   = MV_IDLE;
        pend_clr = '0;
        if (pend[4]) begin
            sel_mv      = MV_ROT;
            pend_clr[4] = 1'b1;
        end else if (pend[3]) begin
            sel_mv      = MV_LEFT;
            pend_clr[3] = 1'b1;
        end else if (pend[2]) begin
            sel_mv      = MV_RIGHT;
            pend_clr[2] = 1'b1;
        end else if (pend[1]) begin
            sel_mv      = MV_DOWN;
            pend_clr[1] = 1'b1;
        end else if (pend[0]) begin
            sel_mv      = MV_DOWN;
            pend_clr[0] = 1'b1;
        end
    end

    piece_candidate u_candidate (
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .block_type (block_type),
        .movement   (movement),
        .next_x     (nxt_x),
        .next_y     (nxt_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_SPAWN;
            lfsr       <= LFSR_SEED;
            pend       <= '0;
            drop_cnt   <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            movement   <= MV_IDLE;
            block_type <= '0;
        end else begin
            lfsr <= lfsr_step(lfsr);
            if (game_over_logic) begin
                movement <= MV_IDLE;
            end else if (block_logic_reset) begin
                state    <= ST_SPAWN;
                movement <= MV_IDLE;
            end else begin
                case (state)
                    ST_SPAWN: begin
                        block_type <= lfsr;
                        cur_x      <= spawn.x;
                        cur_y      <= spawn.y;
                        pend       <= '0;
                        movement   <= MV_IDLE;
                        state      <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        // A fresh pulse of the request being serviced re-arms it.
                        pend     <= (pend & ~pend_clr) | pend_set;
                        movement <= sel_mv;
                        if (sel_mv != MV_IDLE)
                            state <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        cur_x    <= chg_x;
                        cur_y    <= chg_y;
                        pend     <= pend | pend_set;
                        movement <= MV_IDLE;
                        state    <= ST_ACTIVE;
                    end
                    default: begin
                        movement <= MV_IDLE;
                        state    <= ST_SPAWN;
                    end
                endcase

                if (state == ST_SPAWN)
                    drop_cnt <= '0;
                else if (ce)
                    drop_cnt <= (drop_cnt == CNT_LAST) ? '0 : drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: expectations are queued as stimulus
// is applied and popped against the outputs one cycle-step later.
module tb_piece_controller;

    localparam int K_MV  = 0;
    localparam int K_NXT = 1;
    localparam int K_CUR = 2;
    localparam int K_BT  = 3;

    localparam int B_ROT   = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_DOWN  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0, btn_down = 1'b0;
    logic block_logic_reset = 1'b0;
    logic game_over_logic = 1'b0;
    logic cmode = 1'b0;

    logic [3:0] changed_x1, changed_x2, changed_x3, changed_x4;
    logic [4:0] changed_y1, changed_y2, changed_y3, changed_y4;
    logic [3:0] x1, x2, x3, x4;
    logic [4:0] y1, y2, y3, y4;
    logic [3:0] x1_next_out, x2_next_out, x3_next_out, x4_next_out;
    logic [4:0] y1_next_out, y2_next_out, y3_next_out, y4_next_out;
    logic [3:0] movement;
    logic [2:0] block_type;

    logic [2:0] lm;
    logic [2:0] exp_bt;

    string       tq[$];
    int          kq[$];
    logic [35:0] vq[$];
    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Board-stage stand-in: accept the candidate (cmode=0) or refuse it (cmode=1).
    assign changed_x1 = cmode ? x1 : x1_next_out;
    assign changed_x2 = cmode ? x2 : x2_next_out;
    assign changed_x3 = cmode ? x3 : x3_next_out;
    assign changed_x4 = cmode ? x4 : x4_next_out;
    assign changed_y1 = cmode ? y1 : y1_next_out;
    assign changed_y2 = cmode ? y2 : y2_next_out;
    assign changed_y3 = cmode ? y3 : y3_next_out;
    assign changed_y4 = cmode ? y4 : y4_next_out;

    wire [35:0] obs_cur  = {x4, x3, x2, x1, y4, y3, y2, y1};
    wire [35:0] obs_next = {x4_next_out, x3_next_out, x2_next_out, x1_next_out,
                            y4_next_out, y3_next_out, y2_next_out, y1_next_out};

    piece_controller #(.DROP_TICKS(2), .LFSR_SEED(3'b101)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate), .btn_down(btn_down),
        .block_logic_reset(block_logic_reset), .game_over_logic(game_over_logic),
        .changed_x1(changed_x1), .changed_x2(changed_x2), .changed_x3(changed_x3), .changed_x4(changed_x4),
        .changed_y1(changed_y1), .changed_y2(changed_y2), .changed_y3(changed_y3), .changed_y4(changed_y4),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .x1_next_out(x1_next_out), .x2_next_out(x2_next_out),
        .x3_next_out(x3_next_out), .x4_next_out(x4_next_out),
        .y1_next_out(y1_next_out), .y2_next_out(y2_next_out),
        .y3_next_out(y3_next_out), .y4_next_out(y4_next_out),
        .movement(movement), .block_type(block_type)
    );

    // Reference LFSR: x^3+x^2+1, seed 101 -> 5,3,7,6,4,1,2,...
    function automatic logic [2:0] lfsr_nxt(input logic [2:0] s);
        return {s[1:0], s[2] ^ s[1]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) lm <= 3'b101;
        else       lm <= lfsr_nxt(lm);
    end

    function automatic logic [35:0] cells(input int ax1, input int ay1, input int ax2, input int ay2,
                                          input int ax3, input int ay3, input int ax4, input int ay4);
        return {4'(ax4), 4'(ax3), 4'(ax2), 4'(ax1), 5'(ay4), 5'(ay3), 5'(ay2), 5'(ay1)};
    endfunction

    function automatic logic [35:0] spawn_tbl(input logic [2:0] t);
        case (t)
            3'd1:    return cells(3, 0, 4, 0, 5, 0, 6, 0);
            3'd2:    return cells(4, 0, 5, 0, 4, 1, 5, 1);
            3'd3:    return cells(3, 0, 4, 0, 5, 0, 4, 1);
            3'd4:    return cells(5, 0, 4, 0, 4, 1, 3, 1);
            3'd5:    return cells(3, 0, 4, 0, 5, 0, 3, 1);
            3'd6:    return cells(3, 0, 4, 0, 4, 1, 5, 1);
            3'd7:    return cells(3, 0, 4, 0, 5, 0, 5, 1);
            default: return '0;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int kind, input logic [35:0] val);
        tq.push_back(tag);
        kq.push_back(kind);
        vq.push_back(val);
    endtask

    task automatic drain();
        while (vq.size() > 0) begin
            string       tg;
            int          kd;
            logic [35:0] ev;
            logic [35:0] ov;
            tg = tq.pop_front();
            kd = kq.pop_front();
            ev = vq.pop_front();
            case (kd)
                K_MV:    ov = 36'(movement);
                K_NXT:   ov = obs_next;
                K_CUR:   ov = obs_cur;
                default: ov = 36'(block_type);
            endcase
            checks++;
            assert (ov === ev) passed = passed + 1;
            else begin
                failed = failed + 1;
                $error("FAIL %s observed=%h expected=%h", tg, ov, ev);
            end
        end
    endtask

    task automatic spawn_type(input logic [2:0] t);
        int k;
        k = 0;
        while (lfsr_nxt(lm) != t && k < 10) begin
            step(1);
            k++;
        end
        block_logic_reset = 1'b1;
        step(1);
        block_logic_reset = 1'b0;
        step(1);
        push("spawn_type", K_BT, 36'(t));
        push("spawn_cells", K_CUR, spawn_tbl(t));
        push("spawn_idle", K_MV, 36'd0);
        drain();
    endtask

    task automatic move_step(input int which, input logic [3:0] mv, input logic [35:0] nxt,
                             input logic [35:0] after, input string tag);
        case (which)
            B_ROT:   btn_rotate = 1'b1;
            B_LEFT:  btn_left   = 1'b1;
            B_RIGHT: btn_right  = 1'b1;
            default: btn_down   = 1'b1;
        endcase
        step(1);
        btn_rotate = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_down   = 1'b0;
        step(1);
        push({tag, "_mv"}, K_MV, 36'(mv));
        push({tag, "_next"}, K_NXT, nxt);
        drain();
        step(1);
        push({tag, "_cells"}, K_CUR, after);
        push({tag, "_idle"}, K_MV, 36'd0);
        drain();
    endtask

    initial begin
        step(2);
        push("rst_mv", K_MV, 36'd0);
        push("rst_type", K_BT, 36'd0);
        push("rst_cells", K_CUR, 36'd0);
        push("rst_next", K_NXT, 36'd0);
        drain();

        reset = 1'b0;
        step(1);
        push("first_type", K_BT, 36'd5);
        push("first_cells", K_CUR, cells(3, 0, 4, 0, 5, 0, 3, 1));
        push("first_mv", K_MV, 36'd0);
        drain();

        // I piece walked into the left wall; the fourth shift is suppressed.
        spawn_type(3'd1);
        move_step(B_LEFT, 4'b0011, cells(2, 0, 3, 0, 4, 0, 5, 0), cells(2, 0, 3, 0, 4, 0, 5, 0), "left1");
        move_step(B_LEFT, 4'b0011, cells(1, 0, 2, 0, 3, 0, 4, 0), cells(1, 0, 2, 0, 3, 0, 4, 0), "left2");
        move_step(B_LEFT, 4'b0011, cells(0, 0, 1, 0, 2, 0, 3, 0), cells(0, 0, 1, 0, 2, 0, 3, 0), "left3");
        move_step(B_LEFT, 4'b0011, cells(0, 0, 1, 0, 2, 0, 3, 0), cells(0, 0, 1, 0, 2, 0, 3, 0), "left_wall");

        // T piece: rotation at row 0 would leave the top, then drop to row 5 and rotate.
        spawn_type(3'd3);
        move_step(B_ROT, 4'b1000, cells(3, 0, 4, 0, 5, 0, 4, 1), cells(3, 0, 4, 0, 5, 0, 4, 1), "rot_top");
        for (int k = 0; k < 5; k++)
            move_step(B_DOWN, 4'b0001, cells(3, k + 1, 4, k + 1, 5, k + 1, 4, k + 2),
                      cells(3, k + 1, 4, k + 1, 5, k + 1, 4, k + 2), "down");
        move_step(B_ROT, 4'b1000, cells(4, 4, 4, 5, 4, 6, 3, 5), cells(4, 4, 4, 5, 4, 6, 3, 5), "rot_t");

        spawn_type(3'd2);
        move_step(B_ROT, 4'b1000, cells(4, 0, 5, 0, 4, 1, 5, 1), cells(4, 0, 5, 0, 4, 1, 5, 1), "rot_o");

        // Gravity every second ce; the last step is refused by the board stand-in.
        for (int i = 0; i < 4; i++) begin
            cmode = (i == 3);
            ce = 1'b1;
            step(1);
            ce = 1'b0;
            if (i % 2 == 1) begin
                step(1);
                push("grav_mv", K_MV, 36'd1);
                push("grav_next", K_NXT, (i == 1) ? cells(4, 1, 5, 1, 4, 2, 5, 2) : cells(4, 2, 5, 2, 4, 3, 5, 3));
                drain();
                step(1);
                push("grav_cells", K_CUR, cells(4, 1, 5, 1, 4, 2, 5, 2));
                drain();
                step(1);
            end else begin
                push("grav_wait", K_MV, 36'd0);
                drain();
                step(3);
            end
        end
        cmode = 1'b0;

        // Rotate and right in the same cycle: rotate first, right on the next pass.
        btn_rotate = 1'b1;
        btn_right  = 1'b1;
        step(1);
        btn_rotate = 1'b0;
        btn_right  = 1'b0;
        step(1);
        push("pri_rot_mv", K_MV, 36'd8);
        push("pri_rot_next", K_NXT, cells(4, 1, 5, 1, 4, 2, 5, 2));
        drain();
        step(1);
        push("pri_between", K_MV, 36'd0);
        drain();
        step(1);
        push("pri_right_mv", K_MV, 36'd4);
        push("pri_right_next", K_NXT, cells(5, 1, 6, 1, 5, 2, 6, 2));
        drain();
        step(1);
        push("pri_right_cells", K_CUR, cells(5, 1, 6, 1, 5, 2, 6, 2));
        drain();

        // block_logic_reset during APPLY drops the commit and respawns.
        btn_down = 1'b1;
        step(1);
        btn_down = 1'b0;
        step(1);
        push("blr_apply_mv", K_MV, 36'd1);
        push("blr_apply_next", K_NXT, cells(5, 2, 6, 2, 5, 3, 6, 3));
        drain();
        block_logic_reset = 1'b1;
        step(1);
        block_logic_reset = 1'b0;
        push("blr_no_commit", K_CUR, cells(5, 1, 6, 1, 5, 2, 6, 2));
        push("blr_mv", K_MV, 36'd0);
        drain();
        exp_bt = lm;
        step(1);
        push("blr_type", K_BT, 36'(exp_bt));
        push("blr_cells", K_CUR, spawn_tbl(exp_bt));
        drain();

        // Game over freezes everything, including respawn and pending buttons.
        game_over_logic = 1'b1;
        step(1);
        btn_left = 1'b1;
        block_logic_reset = 1'b1;
        step(1);
        btn_left = 1'b0;
        block_logic_reset = 1'b0;
        step(3);
        push("go_type", K_BT, 36'(exp_bt));
        push("go_cells", K_CUR, spawn_tbl(exp_bt));
        push("go_next", K_NXT, spawn_tbl(exp_bt));
        push("go_mv", K_MV, 36'd0);
        drain();

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        push("async_type", K_BT, 36'd0);
        push("async_cells", K_CUR, 36'd0);
        push("async_mv", K_MV, 36'd0);
        drain();
        game_over_logic = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        push("rerun_type", K_BT, 36'd5);
        push("rerun_cells", K_CUR, cells(3, 0, 4, 0, 5, 0, 3, 1));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/piece_controller.md
Name: piece_controller

Overview:
- Owns the active falling tetromino, upstream of the settling/board stage.
- Spawns pieces and arbitrates player and gravity requests into one movement code per step.
- Drives current cells (x1..x4, y1..y4) and candidate cells (x*_next_out, y*_next_out) to the board stage, then commits the legality-filtered changed_* coordinates it returns.
- Respawns when the board raises block_logic_reset.

Parameters:
- DROP_TICKS, 30, number of ce pulses between gravity steps (minimum 1).
- LFSR_SEED, 3'b101, non-zero reset value of the piece-type LFSR.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  gravity tick enable, the same strobe that steps the board stage.
- btn_left, btn_right, btn_rotate, btn_down  in  1 each  single-cycle request pulses.
- block_logic_reset  in  1  board stage has settled the piece; spawn a new one.
- game_over_logic  in  1  board full; freeze.
- changed_x1..changed_x4  in  4 each  legality-filtered x from the board stage.
- changed_y1..changed_y4  in  5 each  legality-filtered y from the board stage.
- x1..x4  out  4 each  current cell columns, 0..9.
- y1..y4  out  5 each  current cell rows, 0..19.
- x1_next_out..x4_next_out  out  4 each  candidate columns.
- y1_next_out..y4_next_out  out  5 each  candidate rows.
- movement  out  4  0000 idle, 0001 down, 0011 left, 0100 right, 1000 rotate.
- block_type  out  3  1..7 colour/shape code; 0 only in reset.

Behaviour:
Reset (async):
- state=SPAWN; all x/y=0; block_type=0; movement=0; pending flags clear; drop counter=0; LFSR=LFSR_SEED.

LFSR:
- 3-bit Fibonacci LFSR, polynomial x^3+x^2+1.
- Steps every clk and never reaches 0, so it gives values 1..7.

Pending requests:
- Each btn pulse sets a sticky pending bit. The bit clears only when that request is serviced or the piece respawns.
- Gravity: the drop counter increments on ce. At DROP_TICKS-1 it wraps to 0 and sets pend_grav.

FSM:
- SPAWN:
  - block_type<=LFSR value.
  - Load spawn cells (cell2 is the pivot); columns x, rows y:
    - 1 I: (3,0)(4,0)(5,0)(6,0)
    - 2 O: (4,0)(5,0)(4,1)(5,1)
    - 3 T: (3,0)(4,0)(5,0)(4,1)
    - 4 S: (5,0)(4,0)(4,1)(3,1)
    - 5 L: (3,0)(4,0)(5,0)(3,1)
    - 6 Z: (3,0)(4,0)(4,1)(5,1)
    - 7 J: (3,0)(4,0)(5,0)(5,1)
  - Clear pending bits and the drop counter; go to ACTIVE.
- ACTIVE:
  - Select the highest-priority pending request: rotate > left > right > down > gravity. Down and gravity both encode as 0001.
  - Register it into movement, clear its pending bit, go to APPLY.
  - With nothing pending, movement=0000 and the FSM stays in ACTIVE.
- APPLY (exactly 1 cycle):
  - movement and next_out are held stable for this whole cycle.
  - At the clock edge, x/y<=changed_*, movement<=0000, go to ACTIVE.
- A request therefore takes 2 cycles (ACTIVE, then APPLY). Requests arriving mid-step stay pending.

Candidate computation (combinational from current cells and movement):
- left: x-1. right: x+1. down: y+1.
- rotate: clockwise about the pivot (px,py): x'=px-(y-py), y'=py+(x-px), computed signed 6-bit. Type 2 (O) rotate returns the current cells.
- Out of bounds means any candidate x<0, x>9, or y<0. It also means y>19, except for down, where y=20 is legal because the board floor row blocks it.
- When a candidate is out of bounds, all next_out equal the current cells (move suppressed).
- idle: next_out equals the current cells.

Priorities and boundaries:
- block_logic_reset=1 in any state forces SPAWN on the next edge, overriding an APPLY commit.
- game_over_logic=1 freezes the FSM:
  - No spawn, no commit; movement=0000.
  - Pending bits are ignored.
  - Outputs hold their values until reset.
- Reset asserted mid-APPLY: the commit is discarded and reset values apply immediately.
- ce and a button in the same cycle: both pending bits are set, and the button is serviced first.

Decomposition:
- Shared package tetris_pkg:
  - movement codes (MV_IDLE, MV_DOWN, MV_LEFT, MV_RIGHT, MV_ROT);
  - board bounds (COLS=10, ROWS=20);
  - the spawn-offset table indexed by block_type.
- Sub-module piece_candidate: purely combinational candidate, rotate, and bounds check. The FSM, pending bits, LFSR and drop counter stay in the top.

Test Plan:
- Reset release, LFSR_SEED=3'b101 -> next cycle state=ACTIVE, block_type=5, cells (3,0)(4,0)(5,0)(3,1), movement=0000.
- Spawn I, btn_left pulse, loopback changed=next_out -> APPLY cycle: movement=0011, x1..4_next_out=2,3,4,5; following cycle x1..4=2,3,4,5. Repeat 3 times -> third request next_out=current (x1=0 boundary), x unchanged.
- T piece at (3,5)(4,5)(5,5)(4,6), btn_rotate -> next_out (4,4)(4,5)(4,6)(3,5). O piece rotate -> next_out equals current.
- DROP_TICKS=2, ce every 4 clks, no buttons -> movement=0001 after every 2nd ce; y increments by 1 per step. Hold changed_y=y -> position stays unchanged.
- btn_rotate and btn_right in the same cycle -> rotate serviced first, right serviced in the next ACTIVE. block_logic_reset during APPLY -> commit dropped, SPAWN loads a new LFSR type.
- game_over_logic=1 then btn_left and block_logic_reset -> all outputs frozen, movement=0000. Async reset mid-cycle -> outputs return to reset values without waiting for a clk edge.
